// File: rtl/dma_ci_pkg.sv
// Shared constants for the ramDmaCi CI sequencer: opcodes, status-read operand,
// FSM encoding and completion-status bit positions.
package dma_ci_pkg;

    localparam logic [3:0] OP_BUSADDR = 4'b0011;
    localparam logic [3:0] OP_MEMADDR = 4'b0101;
    localparam logic [3:0] OP_BLKSIZE = 4'b0111;
    localparam logic [3:0] OP_BURST   = 4'b1001;
    localparam logic [3:0] OP_CTRL    = 4'b1011;

    localparam logic [31:0] STATUS_READ = 32'h0000_1400;

    localparam int ST_TIMEOUT = 1;
    localparam int ST_BUSERR  = 0;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        W_BUS   = 4'd1,
        W_MEM   = 4'd2,
        W_BLK   = 4'd3,
        W_BURST = 4'd4,
        W_CTRL  = 4'd5,
        GAP     = 4'd6,
        P_RD    = 4'd7,
        CMPL    = 4'd8
    } seqState_t;

    function automatic logic [31:0] ciOpA(input logic [3:0] op);
        return {19'd0, op, 9'd0};
    endfunction

    // States that own a CI transaction (start pulse on entry, wait for done).
    function automatic logic isCiState(input seqState_t s);
        return (s != IDLE) && (s != GAP) && (s != CMPL);
    endfunction

endpackage

// File: rtl/dma_ci_sequencer_if.sv
// Descriptor intake and CI bus between the sequencer (master) and its
// environment: descriptor source plus the DMA engine CI port (slave).
interface dma_ci_sequencer_if;
    logic        descValid;
    logic        descReady;
    logic [31:0] descBusAddr;
    logic [8:0]  descMemAddr;
    logic [9:0]  descBlockSize;
    logic [7:0]  descBurstSize;
    logic        descDirIn;
    logic        ciStart;
    logic [7:0]  ciN;
    logic [31:0] ciValueA;
    logic [31:0] ciValueB;
    logic        ciDone;
    logic [31:0] ciResult;

    modport master (
        input  descValid, descBusAddr, descMemAddr, descBlockSize, descBurstSize, descDirIn,
        input  ciDone, ciResult,
        output descReady, ciStart, ciN, ciValueA, ciValueB
    );

    modport slave (
        output descValid, descBusAddr, descMemAddr, descBlockSize, descBurstSize, descDirIn,
        output ciDone, ciResult,
        input  descReady, ciStart, ciN, ciValueA, ciValueB
    );
endinterface

// File: rtl/dma_poll_timer.sv
// Gap down-counter between status polls and per-descriptor poll counter.
// gapExpire marks the last gap cycle; pollLimit flags the final allowed poll.
module dma_poll_timer #(
    parameter logic [3:0]  POLL_GAP   = 4'd3,
    parameter logic [15:0] POLL_LIMIT = 16'hFFFF
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic gapLoad,
    input  logic gapTick,
    input  logic pollTick,
    output logic gapExpire,
    output logic pollLimit
);
    // At least one gap cycle so the engine has left idle before the first poll.
    localparam logic [3:0] GAP_LOAD = (POLL_GAP == 4'd0) ? 4'd1 : POLL_GAP;

    logic [3:0]  gapCnt;
    logic [15:0] pollCnt;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            gapCnt  <= 4'd0;
            pollCnt <= 16'd0;
        end else begin
            if (gapLoad)
                gapCnt <= GAP_LOAD;
            else if (gapTick && gapCnt != 4'd0)
                gapCnt <= gapCnt - 4'd1;
            if (pollTick)
                pollCnt <= pollCnt + 16'd1;
        end
    end

    assign gapExpire = (gapCnt <= 4'd1);
    assign pollLimit = (pollCnt == POLL_LIMIT);
endmodule

// File: rtl/dma_ci_sequencer.sv
// Programs the ramDmaCi config registers from a descriptor over the CI port,
// starts the transfer and polls engine status until idle or poll timeout.
module dma_ci_sequencer
    import dma_ci_pkg::*;
#(
    parameter logic [7:0]  TARGET_CI_ID = 8'd0,
    parameter logic [3:0]  POLL_GAP     = 4'd3,
    parameter logic [15:0] POLL_LIMIT   = 16'hFFFF
) (
    input  logic                clock,
    input  logic                reset,
    dma_ci_sequencer_if.master  bus,
    output logic                cmplValid,
    output logic [1:0]          cmplStatus,
    output logic                seqBusy,
    output logic [15:0]         cmplCount
);
    seqState_t   state, stateNext;
    logic        accept;
    logic        ciStartQ;
    logic [1:0]  statusQ;
    logic [31:0] busAddrQ;
    logic [8:0]  memAddrQ;
    logic [9:0]  blkQ;
    logic [7:0]  burstQ;
    logic        dirInQ;
    logic        gapExpire, pollLimit;
    logic [31:0] opA, opB;
    logic        unusedResult;

    dma_poll_timer #(.POLL_GAP(POLL_GAP), .POLL_LIMIT(POLL_LIMIT)) timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (accept),
        .gapLoad  (stateNext == GAP && state != GAP),
        .gapTick  (state == GAP),
        .pollTick (stateNext == P_RD && state != P_RD),
        .gapExpire(gapExpire),
        .pollLimit(pollLimit)
    );

    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        case (state)
            IDLE: if (bus.descValid) begin
                accept    = 1'b1;
                stateNext = (bus.descBlockSize == 10'd0) ? CMPL : W_BUS;
            end
            W_BUS:   if (bus.ciDone) stateNext = W_MEM;
            W_MEM:   if (bus.ciDone) stateNext = W_BLK;
            W_BLK:   if (bus.ciDone) stateNext = W_BURST;
            W_BURST: if (bus.ciDone) stateNext = W_CTRL;
            W_CTRL:  if (bus.ciDone) stateNext = GAP;
            GAP:     if (gapExpire)  stateNext = P_RD;
            P_RD: if (bus.ciDone) begin
                if (!bus.ciResult[0] || pollLimit) stateNext = CMPL;
                else                               stateNext = GAP;
            end
            CMPL:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            ciStartQ  <= 1'b0;
            statusQ   <= 2'b00;
            cmplCount <= 16'd0;
            busAddrQ  <= 32'd0;
            memAddrQ  <= 9'd0;
            blkQ      <= 10'd0;
            burstQ    <= 8'd0;
            dirInQ    <= 1'b0;
        end else begin
            state    <= stateNext;
            ciStartQ <= isCiState(stateNext) && (stateNext != state);
            if (accept) begin
                busAddrQ <= bus.descBusAddr;
                memAddrQ <= bus.descMemAddr;
                blkQ     <= bus.descBlockSize;
                burstQ   <= bus.descBurstSize;
                dirInQ   <= bus.descDirIn;
                statusQ  <= 2'b00;
            end
            if (state == P_RD && stateNext == CMPL) begin
                statusQ[ST_TIMEOUT] <= bus.ciResult[0] & pollLimit;
                statusQ[ST_BUSERR]  <= bus.ciResult[1];
            end
            if (state == CMPL)
                cmplCount <= cmplCount + 16'd1;
        end
    end

    always_comb begin
        opA = 32'd0;
        opB = 32'd0;
        case (state)
            W_BUS:   begin opA = ciOpA(OP_BUSADDR); opB = busAddrQ; end
            W_MEM:   begin opA = ciOpA(OP_MEMADDR); opB = {23'd0, memAddrQ}; end
            W_BLK:   begin opA = ciOpA(OP_BLKSIZE); opB = {22'd0, blkQ}; end
            W_BURST: begin opA = ciOpA(OP_BURST);   opB = {24'd0, burstQ}; end
            W_CTRL:  begin opA = ciOpA(OP_CTRL);    opB = dirInQ ? 32'd1 : 32'd2; end
            P_RD:    opA = STATUS_READ;
            default: ;
        endcase
    end

    assign bus.descReady = (state == IDLE);
    assign bus.ciStart   = ciStartQ;
    assign bus.ciN       = ciStartQ ? TARGET_CI_ID : 8'd0;
    assign bus.ciValueA  = opA;
    assign bus.ciValueB  = opB;
    assign seqBusy       = (state != IDLE);
    assign cmplValid     = (state == CMPL);
    assign cmplStatus    = cmplValid ? statusQ : 2'b00;
    assign unusedResult  = ^bus.ciResult[31:2];
endmodule
